// File: rtl/uart_rx_module.sv
// rtl/uart_rx_module.sv - UART receiver: recovers start/data/[parity]/stop frames from seriali
//
// Purpose : Oversampling serial receiver. The line is brought into the clk domain
//           through a 2-FF synchronizer. After a start bit is qualified at
//           mid-bit, every following bit is sampled one full bit period later,
//           so all samples land near bit centres.
// Ports   : clk        - system clock, rising edge
//           reset      - asynchronous, active-low reset
//           seriali    - serial line, idle high, asynchronous to clk
//           data_out   - last good received word, held until the next good frame
//           data_valid - 1-cycle pulse, data_out just updated
//           frame_err  - 1-cycle pulse, stop bit low (or parity mismatch)
//           busy       - high from start-bit detect until the FSM returns to IDLE
// Config  : UART_RX_PARITY_EN - when defined, an even-parity bit follows the data
//           bits; a mismatch is reported through frame_err and the word is dropped.
`timescale 1ns/1ps

module uart_rx_module #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seriali,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 parity_good;

`ifdef UART_RX_PARITY_EN
  logic                 parity_ok_q, parity_ok_d;
  assign parity_good = parity_ok_q;
`else
  assign parity_good = 1'b1;
`endif

  logic rx_s;
  logic half_tick;
  logic full_tick;

  assign rx_s      = sync2_q;
  assign half_tick = (cnt_q == CNT_HALF);
  assign full_tick = (cnt_q == CNT_FULL);

  always_comb begin
    sync1_d  = seriali;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_ok_d = parity_ok_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (half_tick) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            // Line went back high before mid-bit: treat as noise.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (full_tick) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (full_tick) begin
          cnt_d       = '0;
          // Even parity: the parity bit equals the XOR of the data bits.
          parity_ok_d = (rx_s == ^shift_q);
          state_d     = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      ST_STOP: begin
        if (full_tick) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (rx_s && parity_good) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      // Synchronizer preset to the idle line level so reset release is quiet.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_ok_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
`ifdef UART_RX_PARITY_EN
      parity_ok_q <= parity_ok_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule
